// File: rtl/serial_feeder_pkg.sv
// Shared types and defaults for the serial bit feeder.
//   feeder_state_t : FSM encoding (IDLE = shift register empty, SHIFT = emitting a word)
//   DEF_WIDTH      : default parallel word width
package serial_feeder_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } feeder_state_t;

    localparam int unsigned DEF_WIDTH = 8;

endpackage

// File: rtl/serial_bit_feeder_if.sv
// Bundle of the feeder's word handshake, bit strobe and serial outputs.
//   in_data/in_valid/in_ready : parallel word handshake (accept on in_valid && in_ready)
//   bit_en                    : bit-rate strobe
//   dout/dout_valid           : registered serial bit and its qualifier
//   frame_start               : dout holds the first bit of a word
//   busy                      : shift or hold register occupied
// master = word source / bit consumer side, slave = the feeder itself.
interface serial_bit_feeder_if
    import serial_feeder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             bit_en;
    logic             dout;
    logic             dout_valid;
    logic             frame_start;
    logic             busy;

    modport master (
        output in_data,
        output in_valid,
        output bit_en,
        input  in_ready,
        input  dout,
        input  dout_valid,
        input  frame_start,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  bit_en,
        output in_ready,
        output dout,
        output dout_valid,
        output frame_start,
        output busy
    );

endinterface

// File: rtl/feeder_hold_reg.sv
// One-entry word buffer that lets the next word wait while the current one shifts out.
//   clk, rst : clock, asynchronous active-low reset
//   wr_en    : store wr_data (sets full)
//   wr_data  : word to store
//   rd_en    : release the stored word (clears full unless written on the same edge)
//   rd_data  : stored word
//   full     : an entry is held
module feeder_hold_reg
    import serial_feeder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // A write on the same edge as a read wins, so a refill during drain is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (wr_en) begin
            r_full <= 1'b1;
            r_data <= wr_data;
        end else if (rd_en) begin
            r_full <= 1'b0;
        end
    end

    assign rd_data = r_data;
    assign full    = r_full;

endmodule

// File: rtl/serial_bit_feeder.sv
// Serializes parallel words into one bit per enabled cycle for the 1010 detector.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of serial_bit_feeder_if (handshake, bit_en, dout, dout_valid,
//              frame_start, busy)
// Parameters: WIDTH (2..32) bits per word, MSB_FIRST selects the first bit sent.
module serial_bit_feeder
    import serial_feeder_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_bit_feeder_if.slave   bus
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    feeder_state_t    r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_dout, w_dout_nxt;
    logic             r_dout_valid, w_dv_nxt;
    logic             r_frame_start, w_fs_nxt;

    logic             w_hold_full;
    logic [WIDTH-1:0] w_hold_data;
    logic             w_hold_wr;
    logic             w_hold_rd;
    logic             w_accept;
    logic             w_take;
    logic             w_load;
    logic [WIDTH-1:0] w_load_word;
    logic [WIDTH-1:0] w_shifted;

    function automatic logic lead_bit(input logic [WIDTH-1:0] word);
        return MSB_FIRST ? word[WIDTH-1] : word[0];
    endfunction

    assign w_accept = bus.in_valid && !w_hold_full;

    // An edge that may start a new word: idle, or the last bit of the current one.
    assign w_take      = bus.bit_en && ((r_state == IDLE) || (r_cnt == LAST_CNT));
    // The held word has priority; in_ready is low while it is full, so no conflict.
    assign w_load      = w_take && (w_hold_full || w_accept);
    assign w_load_word = w_hold_full ? w_hold_data : bus.in_data;
    assign w_hold_rd   = w_take && w_hold_full;
    // Accepted words not consumed directly by the shift register wait in the hold entry.
    assign w_hold_wr   = w_accept && !w_take;

    assign w_shifted = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};

    feeder_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_hold_wr),
        .wr_data (bus.in_data),
        .rd_en   (w_hold_rd),
        .rd_data (w_hold_data),
        .full    (w_hold_full)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_dout_nxt  = r_dout;
        w_dv_nxt    = r_dout_valid;
        w_fs_nxt    = r_frame_start;

        if (w_load) begin
            w_state_nxt = SHIFT;
            w_shift_nxt = w_load_word;
            w_cnt_nxt   = '0;
            w_dout_nxt  = lead_bit(w_load_word);
            w_dv_nxt    = 1'b1;
            w_fs_nxt    = 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    // Nothing to load; outputs already parked.
                end
                SHIFT: begin
                    if (bus.bit_en) begin
                        if (r_cnt == LAST_CNT) begin
                            // Word finished with nothing queued; dout keeps its last bit.
                            w_state_nxt = IDLE;
                            w_dv_nxt    = 1'b0;
                            w_fs_nxt    = 1'b0;
                        end else begin
                            w_shift_nxt = w_shifted;
                            w_cnt_nxt   = r_cnt + CNT_W'(1);
                            w_dout_nxt  = lead_bit(w_shifted);
                            w_fs_nxt    = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_dout        <= 1'b0;
            r_dout_valid  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shift       <= w_shift_nxt;
            r_cnt         <= w_cnt_nxt;
            r_dout        <= w_dout_nxt;
            r_dout_valid  <= w_dv_nxt;
            r_frame_start <= w_fs_nxt;
        end
    end

    assign bus.in_ready    = !w_hold_full;
    assign bus.dout        = r_dout;
    assign bus.dout_valid  = r_dout_valid;
    assign bus.frame_start = r_frame_start;
    assign bus.busy        = (r_state == SHIFT) || w_hold_full;

endmodule
